// File: rtl/i2s_sample_rx_if.sv
// Bundle between the codec serial pins and the sample word handed to the pitch-shift datapath.
// The slave modport belongs to the receiver; the master modport drives the codec pins and observes results.
interface i2s_sample_rx_if #(
  parameter int WIDTH = 16
);
  logic             bclk;
  logic             lrclk;
  logic             sdata;
  logic [WIDTH-1:0] Sample;
  logic             ready;
  logic             frame_err;

  modport master (
    output bclk,
    output lrclk,
    output sdata,
    input  Sample,
    input  ready,
    input  frame_err
  );

  modport slave (
    input  bclk,
    input  lrclk,
    input  sdata,
    output Sample,
    output ready,
    output frame_err
  );
endinterface

// File: rtl/i2s_sample_rx.sv
// I2S ADC receiver for one channel: oversamples bclk/lrclk/sdata in the system clock domain
// and emits each complete WIDTH-bit word with a one-cycle ready strobe.
module i2s_sample_rx #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           channel_sel,
  i2s_sample_rx_if.slave bus
);

  localparam int              CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    SHIFT,
    DONE
  } state_e;

  logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
  logic [SYNC_STAGES-1:0] lrclk_sync_q, lrclk_sync_d;
  logic [SYNC_STAGES-1:0] sdata_sync_q, sdata_sync_d;
  logic                   bclk_prev_q, bclk_prev_d;
  logic                   rise_q, rise_d;
  logic                   lr_q, lr_d;
  logic                   sd_q, sd_d;
  logic                   seen_q, seen_d;
  logic                   slot_ch_q, slot_ch_d;
  logic                   cap_q, cap_d;
  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       shift_q, shift_d;
  logic [CNT_W-1:0]       bitcnt_q, bitcnt_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [WIDTH-1:0]       sample_q, sample_d;
  logic                   ready_q, ready_d;
  logic                   frame_err_q, frame_err_d;
  logic                   slot_start;

  // Front end: synchronisers plus a registered rise detect. lr_q/sd_q are
  // registered alongside rise_q so they carry the values seen at that bclk rise.
  always_comb begin
    bclk_sync_d  = {bclk_sync_q[SYNC_STAGES-2:0], bus.bclk};
    lrclk_sync_d = {lrclk_sync_q[SYNC_STAGES-2:0], bus.lrclk};
    sdata_sync_d = {sdata_sync_q[SYNC_STAGES-2:0], bus.sdata};
    bclk_prev_d  = bclk_sync_q[SYNC_STAGES-1];
    rise_d       = bclk_sync_q[SYNC_STAGES-1] & ~bclk_prev_q;
    lr_d         = lrclk_sync_q[SYNC_STAGES-1];
    sd_d         = sdata_sync_q[SYNC_STAGES-1];
  end

  // The first rise after reset only records lrclk, so a slot already in
  // progress at release never looks like a slot start.
  always_comb begin
    slot_start  = rise_q & seen_q & (lr_q != slot_ch_q);
    seen_d      = seen_q;
    slot_ch_d   = slot_ch_q;
    cap_d       = cap_q;
    state_d     = state_q;
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    ready_d     = done_q;
    frame_err_d = err_q;
    sample_d    = done_q ? shift_q : sample_q;

    if (rise_q) begin
      seen_d    = 1'b1;
      slot_ch_d = lr_q;
      if (slot_start) begin
        cap_d = (lr_q == channel_sel);
      end
      unique case (state_q)
        IDLE: begin
          if (slot_start) begin
            state_d = DELAY;
          end
        end
        DELAY: begin
          if (slot_start) begin
            err_d = 1'b1;
          end else begin
            shift_d  = {shift_q[WIDTH-2:0], sd_q};
            bitcnt_d = '0;
            state_d  = SHIFT;
          end
        end
        SHIFT: begin
          shift_d  = {shift_q[WIDTH-2:0], sd_q};
          bitcnt_d = bitcnt_q + CNT_W'(1);
          // With exactly WIDTH-bit slots the LSB arrives on the next slot's first rise.
          if (bitcnt_q == LAST_CNT) begin
            done_d  = cap_q;
            state_d = slot_start ? DELAY : DONE;
          end else if (slot_start) begin
            err_d   = 1'b1;
            state_d = DELAY;
          end
        end
        DONE: begin
          if (slot_start) begin
            state_d = DELAY;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bclk_sync_q  <= '0;
      lrclk_sync_q <= '0;
      sdata_sync_q <= '0;
      bclk_prev_q  <= 1'b0;
      rise_q       <= 1'b0;
      lr_q         <= 1'b0;
      sd_q         <= 1'b0;
      seen_q       <= 1'b0;
      slot_ch_q    <= 1'b0;
      cap_q        <= 1'b0;
      state_q      <= IDLE;
      shift_q      <= '0;
      bitcnt_q     <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      sample_q     <= '0;
      ready_q      <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      bclk_sync_q  <= bclk_sync_d;
      lrclk_sync_q <= lrclk_sync_d;
      sdata_sync_q <= sdata_sync_d;
      bclk_prev_q  <= bclk_prev_d;
      rise_q       <= rise_d;
      lr_q         <= lr_d;
      sd_q         <= sd_d;
      seen_q       <= seen_d;
      slot_ch_q    <= slot_ch_d;
      cap_q        <= cap_d;
      state_q      <= state_d;
      shift_q      <= shift_d;
      bitcnt_q     <= bitcnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
      sample_q     <= sample_d;
      ready_q      <= ready_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.Sample    = sample_q;
  assign bus.ready     = ready_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_i2s_sample_rx.sv
// Directed bench for i2s_sample_rx: drives I2S frames at clk/8 and clk/4 and checks
// captured words, strobes, latency, short-slot errors and mid-slot reset recovery.
module tb_i2s_sample_rx;

  localparam int WIDTH       = 16;
  localparam int SYNC_STAGES = 2;

  logic clk = 1'b0;
  logic reset;
  logic channel_sel;

  i2s_sample_rx_if #(.WIDTH(WIDTH)) bus ();

  i2s_sample_rx #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .channel_sel(channel_sel),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int cyc            = 0;
  int ready_cnt      = 0;
  int err_cnt        = 0;
  int both_cnt       = 0;
  int last_ready_cyc = 0;
  int lsb_cyc        = 0;
  int half           = 4;
  int checks         = 0;
  int errors         = 0;
  logic carry        = 1'b0;
  logic carry_lsb    = 1'b0;
  logic [WIDTH-1:0] got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Passive recorder of output strobes; all judgements happen in the main sequence.
  always @(negedge clk) begin
    if (bus.ready) begin
      ready_cnt      <= ready_cnt + 1;
      last_ready_cyc <= cyc;
      got_q.push_back(bus.Sample);
    end
    if (bus.frame_err) err_cnt <= err_cnt + 1;
    if (bus.ready && bus.frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bclk period: data and lrclk change with the falling edge.
  task automatic send_bit(input logic lr, input logic d, input logic lsb);
    bus.bclk  = 1'b0;
    bus.lrclk = lr;
    bus.sdata = d;
    repeat (half) @(negedge clk);
    bus.bclk = 1'b1;
    if (lsb) lsb_cyc = cyc + 1;
    repeat (half) @(negedge clk);
  endtask

  // Period 0 of a slot carries the previous word's LSB (I2S one-bit delay).
  task automatic send_slot(input logic ch, input logic [WIDTH-1:0] word, input int nbits,
                           input int toggle_at);
    logic d;
    logic lsb;
    for (int p = 0; p < nbits; p++) begin
      if (p == toggle_at) channel_sel = ~channel_sel;
      if (p == 0) begin
        d   = carry;
        lsb = carry_lsb;
      end else if (p <= WIDTH) begin
        d   = word[WIDTH-p];
        lsb = (p == WIDTH) && (ch == 1'b0);
      end else begin
        d   = 1'b0;
        lsb = 1'b0;
      end
      send_bit(ch, d, lsb);
    end
    if (nbits == WIDTH) begin
      carry     = word[0];
      carry_lsb = (ch == 1'b0);
    end else begin
      carry     = 1'b0;
      carry_lsb = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r, input int nbits);
    send_slot(1'b0, l, nbits, -1);
    send_slot(1'b1, r, nbits, -1);
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
    #1;
  endtask

  initial begin
    int r0;
    int e0;
    logic [WIDTH-1:0] lw;
    logic [WIDTH-1:0] rw;
    logic [WIDTH-1:0] exp_q[$];

    reset       = 1'b0;
    channel_sel = 1'b0;
    bus.bclk    = 1'b0;
    bus.lrclk   = 1'b0;
    bus.sdata   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_output("reset_sample", 32'(bus.Sample), 32'h0);
    check_output("reset_ready", 32'(bus.ready), 32'h0);
    check_output("reset_frame_err", 32'(bus.frame_err), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] left channel, 32-bit slots, bclk=clk/8");
    r0 = ready_cnt;
    e0 = err_cnt;
    send_slot(1'b1, 16'h0000, 32, -1);
    repeat (3) send_frame(16'h8001, 16'h1234, 32);
    settle();
    check_output("t1_ready_count", 32'(ready_cnt - r0), 32'd3);
    check_output("t1_sample", 32'(bus.Sample), 32'h8001);
    check_output("t1_frame_err", 32'(err_cnt - e0), 32'd0);

    $display("[TB] right channel, then channel_sel change mid left slot");
    channel_sel = 1'b1;
    r0 = ready_cnt;
    repeat (2) send_frame(16'h8001, 16'h1234, 32);
    settle();
    check_output("t2_ready_count", 32'(ready_cnt - r0), 32'd2);
    check_output("t2_sample", 32'(bus.Sample), 32'h1234);
    r0 = ready_cnt;
    send_slot(1'b0, 16'h8001, 32, 10);
    send_slot(1'b1, 16'h1234, 32, -1);
    settle();
    check_output("t2_toggle_no_ready", 32'(ready_cnt - r0), 32'd0);
    check_output("t2_toggle_sel_value", 32'(channel_sel), 32'd0);
    r0 = ready_cnt;
    send_frame(16'h8001, 16'h1234, 32);
    settle();
    check_output("t2_after_toggle_count", 32'(ready_cnt - r0), 32'd1);
    check_output("t2_after_toggle_sample", 32'(bus.Sample), 32'h8001);

    $display("[TB] 16-bit slots and ready latency");
    r0 = ready_cnt;
    e0 = err_cnt;
    repeat (3) send_frame(16'hFFFF, 16'h0000, 16);
    settle();
    check_output("t3_ready_count", 32'(ready_cnt - r0), 32'd3);
    check_output("t3_sample", 32'(bus.Sample), 32'hFFFF);
    check_output("t3_frame_err", 32'(err_cnt - e0), 32'd0);
    check_output("t3_latency", 32'(last_ready_cyc - lsb_cyc), 32'(SYNC_STAGES + 2));

    $display("[TB] short left slot");
    r0 = ready_cnt;
    e0 = err_cnt;
    send_slot(1'b0, 16'h5A5A, 10, -1);
    send_slot(1'b1, 16'h1234, 32, -1);
    settle();
    check_output("t4_frame_err_count", 32'(err_cnt - e0), 32'd1);
    check_output("t4_no_ready", 32'(ready_cnt - r0), 32'd0);
    r0 = ready_cnt;
    send_frame(16'h8001, 16'h1234, 32);
    settle();
    check_output("t4_recover_count", 32'(ready_cnt - r0), 32'd1);
    check_output("t4_recover_sample", 32'(bus.Sample), 32'h8001);

    $display("[TB] reset mid-shift");
    r0 = ready_cnt;
    e0 = err_cnt;
    send_slot(1'b1, 16'h0000, 32, -1);
    send_slot(1'b0, 16'hA5A5, 8, -1);
    reset = 1'b0;
    #1;
    check_output("t5_reset_sample", 32'(bus.Sample), 32'h0);
    check_output("t5_reset_ready", 32'(bus.ready), 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    send_slot(1'b0, 16'h0000, 24, -1);
    send_slot(1'b1, 16'h1234, 32, -1);
    settle();
    check_output("t5_lost_word", 32'(ready_cnt - r0), 32'd0);
    send_frame(16'h8001, 16'h1234, 32);
    settle();
    check_output("t5_recover_count", 32'(ready_cnt - r0), 32'd1);
    check_output("t5_recover_sample", 32'(bus.Sample), 32'h8001);
    check_output("t5_frame_err", 32'(err_cnt - e0), 32'd0);

    $display("[TB] random data at bclk=clk/4");
    half = 2;
    e0   = err_cnt;
    got_q.delete();
    for (int i = 0; i < 150; i++) begin
      lw = WIDTH'($urandom);
      rw = WIDTH'($urandom);
      exp_q.push_back(lw);
      send_frame(lw, rw, 32);
    end
    settle();
    check_output("t6_word_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check_output($sformatf("t6_word_%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    check_output("t6_frame_err", 32'(err_cnt - e0), 32'd0);
    check_output("ready_err_overlap", 32'(both_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
